ctrl_sequencer: RTL
===================

# ctrl_sequencer

Upstream command sequencer for `controller`. It accepts a host word stream over a valid/ready handshake and buffers it in a small FIFO. It parses command packets of the form {mode, length/flags, optional data words} and drives the `controller` inputs `enable`, `mode` and `in_data` cycle by cycle. It provides stall control when the data stream runs dry, so long load/compute schedules no longer have to be hand-sequenced.

## Interface
- `DATA_W`, 32: width of host words, `mode` and `in_data`.
- `FIFO_DEPTH`, 8: input FIFO entries; must be a power of two and ≥ 2.
- `LEN_W`, 16: length field width, taken from header word 1 bits [LEN_W-1:0].
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Asserting (0) clears all state immediately.
- `s_valid` input 1: host word valid.
- `s_ready` output 1: FIFO can accept a word.
- `s_data` input DATA_W: host word.
- `enable` output 1: drives `controller.enable`.
- `mode` output DATA_W: drives `controller.mode`.
- `in_data` output DATA_W, signed: drives `controller.in_data`.
- `cmd_done` output 1: one-cycle pulse on the cycle the last output beat of a command is driven. It fires again on the gap beat if a gap is requested.
- `idle` output 1: FSM is in FETCH_MODE and the FIFO is empty.

## Operation
- Packet format:
  - Word 0: mode value.
  - Word 1: bits [LEN_W-1:0] = LEN (number of output beats).
  - Word 1 bit 30 = GAP: append one beat with mode=0, in_data=0.
  - Word 1 bit 31 = HAS_DATA: LEN data words follow.
  - Word 1 bits [29:LEN_W] are ignored.
- FIFO:
  - Show-ahead: the head is visible combinationally when not empty.
  - A write occurs when `s_valid && s_ready`.
  - `s_ready` = !full, computed from the registered count.
  - When full, a same-cycle pop does not raise `s_ready`.
- FSM states: FETCH_MODE, FETCH_LEN, RUN_DATA, RUN_HOLD, GAP.
  - FETCH_MODE: pop on non-empty, latch mode_reg → FETCH_LEN.
  - FETCH_LEN: pop on non-empty, load beat counter = LEN.
    - LEN=0 → GAP if GAP is set, else FETCH_MODE.
    - Otherwise → RUN_DATA if HAS_DATA is set, else RUN_HOLD.
  - RUN_DATA, FIFO non-empty: pop, register enable=1, mode=mode_reg, in_data=head, decrement counter.
  - RUN_DATA, FIFO empty: register enable=0; mode and in_data hold their previous values; counter unchanged.
  - RUN_HOLD: register enable=1, mode=mode_reg, in_data=0 each cycle; decrement counter.
  - When the counter reaches 0 on a beat: assert `cmd_done`, then → GAP if GAP is set, else FETCH_MODE.
  - GAP: register enable=1, mode=0, in_data=0, then → FETCH_MODE.
- In FETCH_MODE and FETCH_LEN: enable=0; mode and in_data keep their last driven value (mode=0 after reset).
- Counter is LEN_W bits. LEN=2^LEN_W−1 is legal; there is no wrap.

## Timing
- Reset values: `s_ready`=1, `enable`=0, `mode`=0, `in_data`=0, `cmd_done`=0, `idle`=1. FIFO is empty and the FSM is in FETCH_MODE.
- All outputs except `s_ready` are registered.
- Latency with back-to-back host words:
  - Header word 0 accepted at edge 0.
  - Popped at edge 1; word 1 popped at edge 2.
  - First beat visible after edge 3.
- Sustained throughput is 1 beat per cycle once the FIFO is non-empty.
- Commands chain with exactly 2 enable=0 header cycles between them.
- Reset mid-command: outputs return to reset values asynchronously and any partial packet is discarded.
- Simultaneous write and pop when the FIFO is not full: the count is unchanged.

## Structure
- `ctrl_seq_pkg` holds:
  - The state enum.
  - Localparams: flag bit positions HAS_DATA=31 and GAP=30.
  - Default widths.
- Sub-module `sync_fifo`: show-ahead, parameterised by DATA_W and FIFO_DEPTH. Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty.
- `ctrl_sequencer` holds the FSM, counter and output registers.

## Test plan
- Data command: send 0x0182, 0x80000003, 1, 0, 1 back-to-back → enable=1 for 3 cycles with mode=0x0182 and in_data=1,0,1; `cmd_done` on the 3rd beat.
- Hold command with gap: send 0x1801, 0x40000060 → 96 beats of mode=0x1801, in_data=0, then 1 beat of mode=0, enable=1, then enable=0.
- Stall: data command with LEN=4, withholding `s_valid` after 2 data words for 5 cycles → enable=0 for those cycles with mode and in_data held; remaining 2 beats follow and `cmd_done` asserts once.
- Back-pressure: hold the controller side idle and push 9 words with FIFO_DEPTH=8 → `s_ready`=0 after 8 writes; word 9 is accepted only after the first pop; no word is lost or duplicated.
- LEN=0: send 0x0102, 0x00000000, then 0x0182, 0x80000001, 5 → no beat for 0x0102; a single beat mode=0x0182, in_data=5.
- Reset mid-RUN_HOLD (beat 40 of 96) → `enable`/`mode`=0 immediately and `idle`=1. A new packet after release executes normally.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the controller command sequencer.
package ctrl_seq_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int LEN_W_DEF      = 16;

    // Flag positions inside header word 1
    localparam int HAS_DATA_BIT = 31;
    localparam int GAP_BIT      = 30;

    typedef enum logic [2:0] {
        FETCH_MODE,
        FETCH_LEN,
        RUN_DATA,
        RUN_HOLD,
        GAP
    } seq_state_e;

endpackage

// File: rtl/ctrl_sequencer_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible whenever not empty.
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic do_wr;
    logic do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage is not reset: only pointers and count define visible contents
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Parses {mode, length/flags, data...} packets from a host FIFO and drives
// the controller enable/mode/in_data inputs one beat per cycle.
//
// state      | meaning
// FETCH_MODE | wait for / pop header word 0 (mode)
// FETCH_LEN  | wait for / pop header word 1 (LEN, GAP, HAS_DATA)
// RUN_DATA   | one beat per popped data word; stalls with enable=0 when dry
// RUN_HOLD   | LEN beats with in_data=0, no FIFO reads
// GAP        | single trailing beat with mode=0, in_data=0
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     enable,
    output logic [DATA_W-1:0]        mode,
    output logic signed [DATA_W-1:0] in_data,
    output logic                     cmd_done,
    output logic                     idle
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] mode_reg_q, mode_reg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              gap_q, gap_d;
    logic              en_d;
    logic              done_d;
    logic [DATA_W-1:0] mode_d;
    logic [DATA_W-1:0] data_d;

    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    assign s_ready = !full;
    assign idle    = (state_q == FETCH_MODE) && empty;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d    = state_q;
        mode_reg_d = mode_reg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        en_d       = 1'b0;
        done_d     = 1'b0;
        mode_d     = mode;
        data_d     = in_data;
        pop        = 1'b0;

        case (state_q)
            FETCH_MODE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    mode_reg_d = head;
                    state_d    = FETCH_LEN;
                end
            end
            FETCH_LEN: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = head[LEN_W-1:0];
                    gap_d = head[GAP_BIT];
                    if (head[LEN_W-1:0] == '0) begin
                        state_d = head[GAP_BIT] ? GAP : FETCH_MODE;
                    end else begin
                        state_d = head[HAS_DATA_BIT] ? RUN_DATA : RUN_HOLD;
                    end
                end
            end
            RUN_DATA: begin
                if (!empty) begin
                    pop    = 1'b1;
                    en_d   = 1'b1;
                    mode_d = mode_reg_q;
                    data_d = head;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = gap_q ? GAP : FETCH_MODE;
                    end
                end
            end
            RUN_HOLD: begin
                en_d   = 1'b1;
                mode_d = mode_reg_q;
                data_d = '0;
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = gap_q ? GAP : FETCH_MODE;
                end
            end
            GAP: begin
                en_d    = 1'b1;
                mode_d  = '0;
                data_d  = '0;
                done_d  = 1'b1;
                state_d = FETCH_MODE;
            end
            default: state_d = FETCH_MODE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH_MODE;
            mode_reg_q <= '0;
            cnt_q      <= '0;
            gap_q      <= 1'b0;
            enable     <= 1'b0;
            mode       <= '0;
            in_data    <= '0;
            cmd_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_reg_q <= mode_reg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            enable     <= en_d;
            mode       <= mode_d;
            in_data    <= data_d;
            cmd_done   <= done_d;
        end
    end

endmodule
